// File: rtl/hdmi_packet_serializer.sv
// HDMI data-island packet serializer: 24-bit header + four 56-bit subpackets with BCH ECC, 9 bits/clock over 32 clocks.
// Optional completed-packet counter enabled by defining HDMI_PACKET_STATS_EN.
module hdmi_packet_serializer (
  input  logic         clk_pixel,
  input  logic         rst_n,
  input  logic         data_island_period,
  input  logic [23:0]  header,
  input  logic [223:0] sub,
  output logic [8:0]   packet_data,
  output logic         packet_end
`ifdef HDMI_PACKET_STATS_EN
  ,
  output logic [15:0]  packet_count
`endif
);

  function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
    ecc_step = (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
  endfunction

  logic [4:0]   c;
  logic [23:0]  hdr_sh;
  logic [223:0] sub_sh;
  logic [7:0]   eh;
  logic [7:0]   es [4];

  logic [23:0]  hdr_cur;
  logic [223:0] sub_cur;
  logic [55:0]  sk [4];
  logic         hb;
  logic [3:0]   b0, b1;
  logic [7:0]   eh_nxt;
  logic [7:0]   es_nxt [4];
  logic [7:0]   es_base;

  // Index 0 reads the live inputs while the shadows are being loaded on the same edge.
  always_comb begin
    hdr_cur = (c == '0) ? header : hdr_sh;
    sub_cur = (c == '0) ? sub : sub_sh;
    hb      = (c <= 5'd23) ? hdr_cur[c] : eh[c[2:0]];
    eh_nxt  = ecc_step((c == '0) ? '0 : eh, hb);
    b0      = '0;
    b1      = '0;
    es_base = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      sk[k]     = sub_cur[56*k +: 56];
      es_nxt[k] = '0;
      if (c <= 5'd27) begin
        b0[k] = sk[k][{c, 1'b0}];
        b1[k] = sk[k][{c, 1'b1}];
      end else begin
        b0[k] = es[k][{c[1:0], 1'b0}];
        b1[k] = es[k][{c[1:0], 1'b1}];
      end
      es_base   = (c == '0) ? '0 : es[k];
      es_nxt[k] = ecc_step(ecc_step(es_base, b0[k]), b1[k]);
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      c           <= '0;
      hdr_sh      <= '0;
      sub_sh      <= '0;
      eh          <= '0;
      packet_data <= '0;
      packet_end  <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) es[k] <= '0;
`ifdef HDMI_PACKET_STATS_EN
      packet_count <= '0;
`endif
    end else if (!data_island_period) begin
      c           <= '0;
      packet_data <= '0;
      packet_end  <= 1'b0;
    end else begin
      c           <= c + 5'd1;
      packet_data <= {b1, b0, hb};
      packet_end  <= (c == 5'd31);
      if (c == '0) begin
        hdr_sh <= header;
        sub_sh <= sub;
      end
      if (c <= 5'd23) eh <= eh_nxt;
      if (c <= 5'd27)
        for (int unsigned k = 0; k < 4; k++) es[k] <= es_nxt[k];
`ifdef HDMI_PACKET_STATS_EN
      if (c == 5'd31) packet_count <= packet_count + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_hdmi_packet_serializer.sv
// Directed self-checking bench for hdmi_packet_serializer; expected packets come from a serial-stream reference model.
module tb_hdmi_packet_serializer;

  logic         clk_pixel = 1'b0;
  logic         rst_n;
  logic         data_island_period;
  logic [23:0]  header;
  logic [223:0] sub;
  logic [8:0]   packet_data;
  logic         packet_end;
`ifdef HDMI_PACKET_STATS_EN
  logic [15:0]  packet_count;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [8:0]  rx [32];

  always #5 clk_pixel = ~clk_pixel;

  hdmi_packet_serializer dut (
    .clk_pixel          (clk_pixel),
    .rst_n              (rst_n),
    .data_island_period (data_island_period),
    .header             (header),
    .sub                (sub),
    .packet_data        (packet_data),
    .packet_end         (packet_end)
`ifdef HDMI_PACKET_STATS_EN
    ,
    .packet_count       (packet_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ecc(input logic [63:0] bits, input int n);
    logic [7:0] e = '0;
    for (int i = 0; i < n; i++)
      e = (e >> 1) ^ ((e[0] ^ bits[i]) ? 8'h83 : 8'h00);
    return e;
  endfunction

  // Whole-stream model: header bits then its ECC, subpacket bits then its ECC, then deal into 9-bit words.
  function automatic logic [287:0] model(input logic [23:0] h, input logic [223:0] s);
    logic [31:0]  hbits;
    logic [63:0]  sbits [4];
    logic [55:0]  sk;
    logic [287:0] w = '0;
    hbits = {ecc({40'b0, h}, 24), h};
    for (int k = 0; k < 4; k++) begin
      sk = s[56*k +: 56];
      sbits[k] = {ecc({8'b0, sk}, 56), sk};
    end
    for (int i = 0; i < 32; i++) begin
      w[9*i] = hbits[i];
      for (int k = 0; k < 4; k++) begin
        w[9*i + 1 + k] = sbits[k][2*i];
        w[9*i + 5 + k] = sbits[k][2*i + 1];
      end
    end
    return w;
  endfunction

  // Runs 32 clocks, comparing each word and packet_end; optionally swaps inputs after index chg_at.
  task automatic run_pkt(input string tag, input logic [287:0] exp, input int chg_at,
                         input logic [23:0] h_new, input logic [223:0] s_new);
    logic [31:0] hb;
    logic [63:0] sb;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk_pixel);
      #1;
      rx[i] = packet_data;
      check($sformatf("%s_w%0d", tag, i), {23'b0, packet_data}, {23'b0, exp[9*i +: 9]});
      check($sformatf("%s_end%0d", tag, i), {31'b0, packet_end}, {31'b0, (i == 31)});
      if (i == chg_at) begin
        header = h_new;
        sub    = s_new;
      end
    end
    for (int i = 0; i < 32; i++) hb[i] = rx[i][0];
    check({tag, "_syn_h"}, {24'b0, ecc({32'b0, hb}, 32)}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) begin
        sb[2*i]     = rx[i][1 + k];
        sb[2*i + 1] = rx[i][5 + k];
      end
      check($sformatf("%s_syn_s%0d", tag, k), {24'b0, ecc(sb, 64)}, 32'h0);
    end
  endtask

  task automatic idle(input int n);
    data_island_period = 1'b0;
    repeat (n) @(posedge clk_pixel);
    #1;
  endtask

  task automatic check_count(input string tag, input logic [15:0] exp);
`ifdef HDMI_PACKET_STATS_EN
    check(tag, {16'b0, packet_count}, {16'b0, exp});
`endif
  endtask

  logic [223:0] s_rand, s_a, s_b;
  logic [31:0]  hbits;

  initial begin
    rst_n = 1'b0;
    data_island_period = 1'b0;
    header = '0;
    sub    = '0;
    repeat (2) @(posedge clk_pixel);
    #1;
    check("rst_data", {23'b0, packet_data}, 32'h0);
    check("rst_end", {31'b0, packet_end}, 32'h0);
    check_count("rst_cnt", 16'd0);
    rst_n = 1'b1;
    idle(1);

    // All-zero packet
    data_island_period = 1'b1;
    run_pkt("zero", '0, -1, '0, '0);
    idle(2);
    check_count("cnt1", 16'd1);

    // SPD InfoFrame header with random body
    for (int k = 0; k < 7; k++) s_rand[32*k +: 32] = $urandom;
    header = 24'h190183;
    sub    = s_rand;
    data_island_period = 1'b1;
    run_pkt("spd", model(24'h190183, s_rand), -1, '0, '0);
    idle(1);

    // Single header bit set
    header = 24'h000001;
    sub    = '0;
    data_island_period = 1'b1;
    run_pkt("hb1", model(24'h000001, '0), -1, '0, '0);
    check("hb1_first", {23'b0, rx[0]}, 32'h001);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("hb1_ch%0d", i), {24'b0, rx[i][8:1]}, 32'h0);
      hbits[i] = rx[i][0];
    end
    check("hb1_eh", {24'b0, hbits[31:24]}, {24'b0, ecc(64'h1, 24)});
    idle(1);
    check_count("cnt3", 16'd3);

    // Back-to-back packets; inputs switched to B at index 5 of A
    for (int k = 0; k < 7; k++) begin
      s_a[32*k +: 32] = $urandom;
      s_b[32*k +: 32] = $urandom;
    end
    header = 24'h0D0282;
    sub    = s_a;
    data_island_period = 1'b1;
    run_pkt("b2b_a", model(24'h0D0282, s_a), 5, 24'h0A0184, s_b);
    run_pkt("b2b_b", model(24'h0A0184, s_b), -1, '0, '0);
    idle(1);
    check_count("cnt5", 16'd5);

    // Abort at index 12, then restart with a fresh packet
    header = 24'h123456;
    sub    = s_a;
    data_island_period = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_pixel);
      #1;
      check($sformatf("abt_end%0d", i), {31'b0, packet_end}, 32'h0);
    end
    data_island_period = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_pixel);
      #1;
      check($sformatf("abt_low%0d", i), {22'b0, packet_end, packet_data}, 32'h0);
    end
    check_count("abt_cnt", 16'd5);
    header = 24'h654321;
    sub    = s_b;
    data_island_period = 1'b1;
    run_pkt("rst_pkt", model(24'h654321, s_b), -1, '0, '0);
    idle(1);
    check_count("cnt6", 16'd6);

    // Asynchronous reset at index 20
    header = 24'hABCDEF;
    sub    = s_rand;
    data_island_period = 1'b1;
    repeat (20) @(posedge clk_pixel);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_data", {23'b0, packet_data}, 32'h0);
    check("ar_end", {31'b0, packet_end}, 32'h0);
    check_count("ar_cnt", 16'd0);
    data_island_period = 1'b0;
    @(posedge clk_pixel);
    #1;
    rst_n = 1'b1;
    data_island_period = 1'b1;
    run_pkt("ar_pkt", model(24'hABCDEF, s_rand), -1, '0, '0);
    idle(1);
    check_count("ar_cnt1", 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
